matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
`timescale 1ns/1ps
// matmul_sequencer
// Sequences C = A x B for 3x3 matrices held in an external memory.
// Each C element takes 10 cycles: three (RD_A, RD_B, MAC) passes, then WRITE.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start                 request one computation (only honoured in IDLE)
//   busy, done            busy in RD_A/RD_B/MAC/WRITE; done is a 1-cycle pulse
//   mem_matrix_select     0 = A, 1 = B, 2 = C
//   mem_row, mem_col      element indices 0..2
//   mem_read_enable       read strobe; data returns on mem_read_data a cycle later
//   mem_write_enable      write strobe for mem_write_data
//
// Optional build macro MATMUL_SATURATE_EN: clamp written results to the
// largest DATA_W value instead of truncating to the low DATA_W bits.
//
// state | meaning
// IDLE  | waiting for start
// RD_A  | read A[i][k]
// RD_B  | read B[k][j], capture A element into a_reg
// MAC   | acc += a_reg * B element
// WRITE | write result(acc) to C[i][j], step j/i
// DONE  | one-cycle done pulse
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        mem_matrix_select,
  output logic [1:0]        mem_row,
  output logic [1:0]        mem_col,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WRITE, DONE} state_t;

`ifdef MATMUL_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
`endif

  state_t              state_q, state_d;
  logic [1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   a_reg_q, a_reg_d;
  logic [2*DATA_W-1:0] prod;

  // Outputs are registered: they are decoded from the next state so that
  // they line up with the state they belong to.
  logic              busy_q, busy_d, done_q, done_d;
  logic              re_q, re_d, we_q, we_d;
  logic [1:0]        sel_q, sel_d, row_q, row_d, col_q, col_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign prod = a_reg_q * mem_read_data;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_reg_d = a_reg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
          acc_d   = '0;
          state_d = RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        // A element requested in RD_A is on the read bus now.
        a_reg_d = mem_read_data;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (k_q != 2'd2) begin
          k_d     = k_q + 2'd1;
          state_d = RD_A;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        acc_d = '0;
        k_d   = 2'd0;
        if (j_q != 2'd2) begin
          j_d     = j_q + 2'd1;
          state_d = RD_A;
        end else begin
          j_d = 2'd0;
          if (i_q != 2'd2) begin
            i_d     = i_q + 2'd1;
            state_d = RD_A;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    sel_d   = 2'd0;
    row_d   = 2'd0;
    col_d   = 2'd0;
    wdata_d = '0;
    case (state_d)
      RD_A: begin
        busy_d = 1'b1;
        re_d   = 1'b1;
        sel_d  = 2'd0;
        row_d  = i_d;
        col_d  = k_d;
      end
      RD_B: begin
        busy_d = 1'b1;
        re_d   = 1'b1;
        sel_d  = 2'd1;
        row_d  = k_d;
        col_d  = j_d;
      end
      MAC: busy_d = 1'b1;
      WRITE: begin
        // acc_d already holds the final sum from the last MAC.
        busy_d = 1'b1;
        we_d   = 1'b1;
        sel_d  = 2'd2;
        row_d  = i_q;
        col_d  = j_q;
`ifdef MATMUL_SATURATE_EN
        wdata_d = (acc_d > SAT_MAX) ? {DATA_W{1'b1}} : acc_d[DATA_W-1:0];
`else
        wdata_d = acc_d[DATA_W-1:0];
`endif
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
      acc_q   <= '0;
      a_reg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 2'd0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign mem_read_enable   = re_q;
  assign mem_write_enable  = we_q;
  assign mem_matrix_select = sel_q;
  assign mem_row           = row_q;
  assign mem_col           = col_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
`timescale 1ns/1ps
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic [1:0] sel, row, col;
  logic       we, re;
  logic [7:0] wdata;
  logic [7:0] rdata = 8'd0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] a [3][3];
  logic [7:0] b [3][3];
  logic [7:0] c [3][3];
  int wr_idx_q[$];

  int busy_cnt, done_cnt, done_cyc;
  logic busy92;
  logic [31:0] rst_out;

  matmul_sequencer #(.DATA_W(8), .ACC_W(18)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .mem_matrix_select (sel),
    .mem_row           (row),
    .mem_col           (col),
    .mem_write_enable  (we),
    .mem_read_enable   (re),
    .mem_write_data    (wdata),
    .mem_read_data     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Memory model: registered read, write captured at the clock edge.
  always @(posedge clk) begin
    if (re) rdata <= (sel == 2'd0) ? a[row][col] : (sel == 2'd1) ? b[row][col] : 8'd0;
    if (we) begin
      c[row][col] <= wdata;
      wr_idx_q.push_back(int'(row) * 3 + int'(col));
    end
  end

  always @(negedge clk) begin
    check_val("strobe_excl", {31'd0, re & we}, 32'd0);
    if (!re && !we) check_val("mem_idle_zero", {24'd0, sel, row, col, wdata[1:0]} | {24'd0, wdata}, 32'd0);
  end

  // One operation: start sampled at edge E0, then cycles 1..110 observed.
  // Extra start pulses and a reset can be injected in given cycles.
  task automatic run_op(input int s1, input int s2, input int rst_cyc);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) c[r][q] = 8'hEE;
    wr_idx_q.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; busy92 = 1'bx; rst_out = 32'hFFFF_FFFF;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (cyc == 92) busy92 = busy;
      if (rst_cyc > 0 && cyc == rst_cyc + 1)
        rst_out = {17'd0, busy, done, re, we, sel, row, col, wdata};
      start = (cyc == s1 || cyc == s2);
      reset = (cyc == rst_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] c_exp1 [3][3];
    logic [7:0] sat_exp;
    c_exp1 = '{'{8'd30, 8'd36, 8'd42}, '{8'd66, 8'd81, 8'd96}, '{8'd102, 8'd126, 8'd150}};

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs", {17'd0, busy, done, re, we, sel, row, col, wdata}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1: A = B = 1..9
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) begin
        a[r][q] = 8'(r * 3 + q + 1);
        b[r][q] = 8'(r * 3 + q + 1);
      end
    run_op(0, 0, 0);
    check_val("t1_done_cyc", done_cyc, 91);
    check_val("t1_busy_cnt", busy_cnt, 90);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_writes", wr_idx_q.size(), 9);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++)
        check_val($sformatf("t1_c%0d%0d", r, q), {24'd0, c[r][q]}, {24'd0, c_exp1[r][q]});

    // Test 2: identity x B = B, row-major write order
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) begin
        a[r][q] = (r == q) ? 8'd1 : 8'd0;
        b[r][q] = 8'(9 - (r * 3 + q));
      end
    run_op(0, 0, 0);
    check_val("t2_writes", wr_idx_q.size(), 9);
    for (int n = 0; n < 9; n++)
      if (n < wr_idx_q.size()) check_val($sformatf("t2_order%0d", n), wr_idx_q[n], n);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++)
        check_val($sformatf("t2_c%0d%0d", r, q), {24'd0, c[r][q]}, {24'd0, b[r][q]});

    // Test 3: all 255. Sum = 3*65025 = 195075 = 0x2FA03; low byte 0x03.
`ifdef MATMUL_SATURATE_EN
    sat_exp = 8'd255;
`else
    sat_exp = 8'h03;
`endif
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) begin
        a[r][q] = 8'd255;
        b[r][q] = 8'd255;
      end
    run_op(0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++)
        check_val($sformatf("t3_c%0d%0d", r, q), {24'd0, c[r][q]}, {24'd0, sat_exp});

    // Test 4: start re-pulsed in cycles 5 and 91 is ignored
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++) begin
        a[r][q] = 8'(r * 3 + q + 1);
        b[r][q] = 8'(r * 3 + q + 1);
      end
    run_op(5, 91, 0);
    check_val("t4_done_cnt", done_cnt, 1);
    check_val("t4_done_cyc", done_cyc, 91);
    check_val("t4_busy92", {31'd0, busy92}, 32'd0);
    check_val("t4_busy_cnt", busy_cnt, 90);
    check_val("t4_writes", wr_idx_q.size(), 9);
    check_val("t4_c22", {24'd0, c[2][2]}, 32'd150);

    // Test 5: reset in cycle 40 aborts after the C[1][0] write
    run_op(0, 0, 40);
    check_val("t5_rst_out", rst_out, 32'd0);
    check_val("t5_writes", wr_idx_q.size(), 4);
    check_val("t5_done_cnt", done_cnt, 0);
    check_val("t5_busy_cnt", busy_cnt, 40);
    check_val("t5_c00", {24'd0, c[0][0]}, 32'd30);
    check_val("t5_c01", {24'd0, c[0][1]}, 32'd36);
    check_val("t5_c02", {24'd0, c[0][2]}, 32'd42);
    check_val("t5_c10", {24'd0, c[1][0]}, 32'd66);
    check_val("t5_c11", {24'd0, c[1][1]}, 32'hEE);

    // Test 6: reset wins over start in the same cycle
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_val("t6_rst_prio_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_val("t6_stay_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
